// File: rtl/pow8_acc.sv
// pow8_acc: sums NUM_BEATS consecutive unsigned results (or fewer on flush)
// into one ACC_W-bit total and offers it with its beat count on a registered
// valid/ready master port.
// Optional feature macro: ACC_SAT_EN (saturating accumulator with sticky m_ovf).
// Without it the accumulator wraps modulo 2^ACC_W and m_ovf is tied to 0.
module pow8_acc #(
  parameter int DATA_W    = 64,
  parameter int NUM_BEATS = 4,
  parameter int ACC_W     = 72
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic [7:0]        m_cnt,
  output logic              m_ovf
);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  // Stage 0: running accumulation
  state_t           state_p0;
  logic [ACC_W-1:0] acc_p0;
  logic [7:0]       cnt_p0;

  // Stage 1: completed sum held on the master port
  logic             vld_p1;
  logic [ACC_W-1:0] data_p1;
  logic [7:0]       cnt_p1;

  logic             in_xfer;
  logic             out_xfer;
  logic [ACC_W-1:0] sum_nx;
  logic [7:0]       cnt_nx;
  logic             close_sum;

`ifdef ACC_SAT_EN
  logic ovf_p0;
  logic ovf_p1;
  logic ovf_nx;

  // Add with clamp: once a carry leaves the top bit, the sum pins at all ones
  // and the sticky flag keeps it pinned for the rest of the sum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                             input logic              ovf_in,
                                             input logic [DATA_W-1:0] d);
    logic [ACC_W:0] raw;
    raw = {1'b0, a} + (ACC_W+1)'(d);
    if (raw[ACC_W] || ovf_in) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return {1'b0, raw[ACC_W-1:0]};
  endfunction
`else
  // Plain modulo-2^ACC_W add.
  function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0]  a,
                                                input logic [DATA_W-1:0] d);
    return a + ACC_W'(d);
  endfunction
`endif

  // While accumulating, the input is always open; while a sum is pending the
  // input follows m_ready so a new beat can enter as the sum leaves.
  assign s_ready  = (state_p0 == ST_ACC) || m_ready;
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = vld_p1 && m_ready;

  // Post-edge view of the accumulator and the decision to close the sum.
  always_comb begin
`ifdef ACC_SAT_EN
    {ovf_nx, sum_nx} = in_xfer ? sat_add(acc_p0, ovf_p0, s_data) : {ovf_p0, acc_p0};
`else
    sum_nx = in_xfer ? wrap_add(acc_p0, s_data) : acc_p0;
`endif
    cnt_nx    = cnt_p0 + 8'(in_xfer);
    close_sum = (state_p0 == ST_ACC) &&
                ((in_xfer && (cnt_nx == 8'(NUM_BEATS))) || (flush && (cnt_nx != 8'd0)));
  end

  // Accumulate beats, hand the closed sum to the output register, and reload
  // when the pending sum is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_ACC;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      cnt_p1   <= '0;
`ifdef ACC_SAT_EN
      ovf_p0   <= 1'b0;
      ovf_p1   <= 1'b0;
`endif
    end else begin
      case (state_p0)
        ST_ACC: begin
          if (close_sum) begin
            state_p0 <= ST_OUT;
            vld_p1   <= 1'b1;
            data_p1  <= sum_nx;
            cnt_p1   <= cnt_nx;
            acc_p0   <= '0;
            cnt_p0   <= '0;
`ifdef ACC_SAT_EN
            ovf_p1   <= ovf_nx;
            ovf_p0   <= 1'b0;
`endif
          end else begin
            acc_p0   <= sum_nx;
            cnt_p0   <= cnt_nx;
`ifdef ACC_SAT_EN
            ovf_p0   <= ovf_nx;
`endif
          end
        end
        ST_OUT: begin
          if (out_xfer) begin
            if (in_xfer && (NUM_BEATS == 1)) begin
              // Single-beat sums go straight back out: no bubble.
              data_p1 <= ACC_W'(s_data);
              cnt_p1  <= 8'd1;
`ifdef ACC_SAT_EN
              ovf_p1  <= 1'b0;
`endif
            end else begin
              state_p0 <= ST_ACC;
              vld_p1   <= 1'b0;
              if (in_xfer) begin
                acc_p0 <= ACC_W'(s_data);
                cnt_p0 <= 8'd1;
              end
            end
          end
        end
        default: state_p0 <= ST_ACC;
      endcase
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = data_p1;
  assign m_cnt   = cnt_p1;
`ifdef ACC_SAT_EN
  assign m_ovf   = ovf_p1;
`else
  assign m_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_pow8_acc.sv
// Testbench for pow8_acc: three configurations (4 beats/72b, 1 beat/72b,
// 4 beats/64b), directed scenarios followed by randomized traffic, with a
// queue-based scoreboard fed by a beat-list reference model.
module tb_pow8_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int NB = (g == 1) ? 1 : 4;
    localparam int AW = (g == 2) ? 64 : 72;

    logic          rst     = 1'b1;
    logic          s_valid = 1'b0;
    logic          flush   = 1'b0;
    logic          m_ready = 1'b0;
    logic [63:0]   s_data  = '0;
    logic          s_ready, m_valid, m_ovf;
    logic [AW-1:0] m_data;
    logic [7:0]    m_cnt;
    bit            active  = 1'b0;
    bit            done    = 1'b0;

    // Reference model: sum of beats taken so far, beat count, and whether a
    // finished sum is waiting to be taken by the consumer.
    logic [AW-1:0] q_data[$];
    logic [7:0]    q_cnt[$];
    logic          q_ovf[$];
    logic [AW+9:0] part_sum = '0;
    int            part_n   = 0;
    bit            hold     = 1'b0;

    pow8_acc #(.DATA_W(64), .NUM_BEATS(NB), .ACC_W(AW)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .flush(flush),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_cnt(m_cnt), .m_ovf(m_ovf)
    );

    function void finish_sum();
      logic [AW+9:0] maxv;
      maxv = {10'd0, {AW{1'b1}}};
      if (part_sum > maxv) begin
`ifdef ACC_SAT_EN
        q_data.push_back({AW{1'b1}});
        q_ovf.push_back(1'b1);
`else
        q_data.push_back(part_sum[AW-1:0]);
        q_ovf.push_back(1'b0);
`endif
      end else begin
        q_data.push_back(part_sum[AW-1:0]);
        q_ovf.push_back(1'b0);
      end
      q_cnt.push_back(8'(part_n));
      part_sum = '0;
      part_n   = 0;
      hold     = 1'b1;
    endfunction

    // Model step: predict handshake outputs, then apply this cycle's inputs.
    always @(negedge clk) begin : model
      bit exp_sr;
      bit xin;
      if (active) begin
        exp_sr = !hold || m_ready;
        chk($sformatf("c%0d s_ready", g), 128'(s_ready), 128'(exp_sr));
        chk($sformatf("c%0d m_valid", g), 128'(m_valid), 128'(hold));
        if (rst) begin
          hold = 1'b0; part_sum = '0; part_n = 0;
          q_data.delete(); q_cnt.delete(); q_ovf.delete();
        end else begin
          xin = s_valid && exp_sr;
          if (hold) begin
            if (m_ready) hold = 1'b0;
            if (xin) begin
              part_sum = (AW+10)'(s_data);
              part_n   = 1;
              if (NB == 1) finish_sum();
            end
          end else begin
            if (xin) begin
              part_sum = part_sum + (AW+10)'(s_data);
              part_n++;
            end
            if ((xin && part_n == NB) || (flush && part_n > 0)) finish_sum();
          end
        end
      end
    end

    // Monitor: every output transfer must match the oldest expected sum.
    always @(negedge clk) begin
      if (active && !rst && m_valid && m_ready) begin
        if (q_data.size() == 0) begin
          chk($sformatf("c%0d unexpected output", g), 128'(m_valid), 128'(0));
        end else begin
          chk($sformatf("c%0d m_data", g), 128'(m_data), 128'(q_data.pop_front()));
          chk($sformatf("c%0d m_cnt", g),  128'(m_cnt),  128'(q_cnt.pop_front()));
          chk($sformatf("c%0d m_ovf", g),  128'(m_ovf),  128'(q_ovf.pop_front()));
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      s_valid = 1'b0;
      flush   = 1'b0;
      repeat (n) tick();
    endtask

    task automatic send(input logic [63:0] d, input bit fl);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      flush   = fl;
      @(negedge clk);
      while (!s_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d beat accepted within bound", g), 128'(s_ready), 128'(1));
      tick();
      s_valid = 1'b0;
      flush   = 1'b0;
    endtask

    task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
    endtask

    task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
    endtask

    initial begin
      repeat (3) tick();
      rst    = 1'b0;
      active = 1'b1;
      @(negedge clk);
      chk($sformatf("c%0d reset m_data", g), 128'(m_data), 128'(0));
      chk($sformatf("c%0d reset m_cnt", g),  128'(m_cnt),  128'(0));
      chk($sformatf("c%0d reset m_ovf", g),  128'(m_ovf),  128'(0));
      tick();

      case (g)
        0: begin
          m_ready = 1'b1;
          send(64'd1, 1'b0); send(64'd2, 1'b0); send(64'd3, 1'b0); send(64'd4, 1'b0);
          idle(3);
          m_ready = 1'b0;
          fork
            begin
              repeat (8) send(64'd5, 1'b0);
            end
            begin
              repeat (10) tick();
              m_ready = 1'b1;
            end
          join
          idle(3);
          send(64'd7, 1'b0); send(64'd9, 1'b0);
          pulse_flush(); idle(2);
          pulse_flush(); idle(2);
          send(64'd11, 1'b1); idle(2);
          send(64'd1, 1'b0); send(64'd2, 1'b0);
          pulse_rst();
          send(64'd3, 1'b0); send(64'd3, 1'b0); send(64'd3, 1'b0); send(64'd3, 1'b0);
          idle(3);
        end
        1: begin
          m_ready = 1'b1;
          s_valid = 1'b1;
          for (int i = 0; i < 20; i++) begin
            s_data = 64'(i);
            tick();
          end
          idle(3);
        end
        default: begin
          m_ready = 1'b1;
          repeat (4) send({64{1'b1}}, 1'b0);
          idle(3);
        end
      endcase

      for (int i = 0; i < 400; i++) begin
        s_valid = ($urandom_range(0, 3) != 0);
        if ((g == 2 && $urandom_range(0, 1) == 1) || $urandom_range(0, 7) == 0)
          s_data = {64{1'b1}};
        else if ($urandom_range(0, 1) == 1)
          s_data = 64'($urandom_range(0, 255));
        else
          s_data = {$urandom, $urandom};
        flush   = ($urandom_range(0, 7) == 0);
        m_ready = ($urandom_range(0, 3) != 0);
        rst     = ($urandom_range(0, 199) == 0);
        tick();
      end
      rst     = 1'b0;
      m_ready = 1'b1;
      idle(6);
      chk($sformatf("c%0d sums left undelivered", g), 128'(q_data.size()), 128'(0));
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 20000) begin
      ncmp++;
      nfail++;
      $display("FAIL global timeout: got %0d cycles, want < 20000", cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
